// File: rtl/march_c_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | march_c_sequencer: March C- BIST sequencer with pipelined read compare.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module march_c_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        fail_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] C_ADDR_LAST = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                phase_q, phase_d;
  logic                exp_valid_q, exp_valid_d;
  logic                exp_bit_q, exp_bit_d;
  logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [7:0]          fail_count_q, fail_count_d;

  state_t              next_elem;
  logic                descending;
  logic                pattern;
  logic                mismatch;

  // Pattern is the write value on write ops and the expected value on reads.
  always_comb begin
    pattern    = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    descending = 1'b0;
    next_elem  = S_M5;
    case (state_q)
      S_M0: mem_we = 1'b1;
      S_M1: begin pattern = phase_q;  next_elem = S_M2; end
      S_M2: begin pattern = !phase_q; next_elem = S_M3; end
      S_M3: begin pattern = phase_q;  next_elem = S_M4; descending = 1'b1; end
      S_M4: begin pattern = !phase_q; next_elem = S_M5; descending = 1'b1; end
      S_M5: mem_re = 1'b1;
      default: ;
    endcase
    if (state_q inside {S_M1, S_M2, S_M3, S_M4}) begin
      mem_we = phase_q;
      mem_re = !phase_q;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = {DATA_W{pattern}};
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_count = fail_count_q;
  assign mismatch   = exp_valid_q && (mem_rdata != {DATA_W{exp_bit_q}});

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    exp_valid_d  = mem_re;
    exp_bit_d    = pattern;
    exp_addr_d   = addr_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;

    if (mismatch) begin
      fail_d = 1'b1;
      if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
      if (!fail_q) fail_addr_d = exp_addr_q;
    end

    if (abort) begin
      state_d     = S_IDLE;
      addr_d      = '0;
      phase_d     = 1'b0;
      exp_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d      = S_M0;
            addr_d       = '0;
            phase_d      = 1'b0;
            fail_d       = 1'b0;
            fail_addr_d  = '0;
            fail_count_d = '0;
          end
        end
        S_M0: begin
          if (addr_q == C_ADDR_LAST) begin
            state_d = S_M1;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        S_M1, S_M2, S_M3, S_M4: begin
          phase_d = !phase_q;
          if (phase_q) begin
            // Exit on the terminal address, never on wrap-around.
            if (addr_q == (descending ? '0 : C_ADDR_LAST)) begin
              state_d = next_elem;
              addr_d  = (next_elem == S_M3 || next_elem == S_M4) ? C_ADDR_LAST : '0;
            end else begin
              addr_d = descending ? addr_q - 1'b1 : addr_q + 1'b1;
            end
          end
        end
        S_M5: begin
          if (addr_q == C_ADDR_LAST) begin
            state_d = S_DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        S_DRAIN: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      phase_q      <= 1'b0;
      exp_valid_q  <= 1'b0;
      exp_bit_q    <= 1'b0;
      exp_addr_q   <= '0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      exp_valid_q  <= exp_valid_d;
      exp_bit_q    <= exp_bit_d;
      exp_addr_q   <= exp_addr_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
    end
  end

endmodule
`default_nettype wire
